// File: rtl/eth_pcs_pkg.sv
// Shared 64b/66b PCS definitions: sync-header codes, header validity check, block-lock states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package eth_pcs_pkg;

    // 64b/66b sync header codes; the other two codes never appear on an aligned lane.
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    // Block-lock FSM states; the encoding is exported on the debug bus.
    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } block_lock_state_t;

    // A header is valid only if it is one of the two legal sync codes.
    function automatic logic sh_is_valid(input logic [1:0] header);
        return (header == SH_DATA) || (header == SH_CTRL);
    endfunction

endpackage

// File: rtl/gtx_rx_block_lock.sv
// 64b/66b block-lock FSM: slips the GTX RX gearbox until sync headers align, then monitors header errors.
// Latency: 1 cycle from the header-valid cycle to o_rxslip / o_block_lock response; all outputs registered.
// Backpressure: none; every header-valid cycle is consumed, headers during a slip wait are discarded.
//
// Ports:
//   i_clk            RX user clock (lane header domain)
//   i_rst_n          synchronous active-low reset
//   i_rx_header      2-bit sync header from the GTX
//   i_rx_headervalid i_rx_header qualifier
//   o_rxslip         single-cycle slip request to the GTX
//   o_block_lock     high while block lock is held
//   o_state          current FSM state (debug bus)
//   o_slip_count     saturating count of slips issued since reset
module gtx_rx_block_lock
    import eth_pcs_pkg::*;
#(
    parameter int LOCK_COUNT       = 64,
    parameter int BAD_WINDOW       = 64,
    parameter int BAD_LIMIT        = 16,
    parameter int SLIP_WAIT_CYCLES = 32,
    parameter int SLIP_CNT_WIDTH   = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [1:0]                i_rx_header,
    input  logic                      i_rx_headervalid,
    output logic                      o_rxslip,
    output logic                      o_block_lock,
    output logic [1:0]                o_state,
    output logic [SLIP_CNT_WIDTH-1:0] o_slip_count
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    generate
        if (LOCK_COUNT <= 0 || BAD_WINDOW <= 0 || BAD_LIMIT <= 0 ||
            SLIP_WAIT_CYCLES <= 0 || SLIP_CNT_WIDTH <= 0) begin : g_bad_zero
            $error("gtx_rx_block_lock: count parameters must be non-zero");
        end
        if (BAD_LIMIT > BAD_WINDOW) begin : g_bad_limit
            $error("gtx_rx_block_lock: BAD_LIMIT must not exceed BAD_WINDOW");
        end
    endgenerate

    // sh_cnt serves both the HUNT run length and the LOCKED window, so it is
    // sized for whichever limit is larger.
    localparam int SH_MAX = (LOCK_COUNT > BAD_WINDOW) ? LOCK_COUNT : BAD_WINDOW;
    localparam int SH_W   = $clog2(SH_MAX) + 1;
    localparam int BAD_W  = $clog2(BAD_LIMIT) + 1;
    localparam int WAIT_W = $clog2(SLIP_WAIT_CYCLES) + 1;

    localparam logic [SH_W-1:0]   SH_LOCK_LAST  = SH_W'(LOCK_COUNT);
    localparam logic [SH_W-1:0]   SH_WIN_LAST   = SH_W'(BAD_WINDOW);
    localparam logic [BAD_W-1:0]  BAD_LAST      = BAD_W'(BAD_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST     = WAIT_W'(SLIP_WAIT_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    block_lock_state_t         state_q;
    logic [SH_W-1:0]           sh_cnt_q;
    logic [BAD_W-1:0]          bad_cnt_q;
    logic [WAIT_W-1:0]         wait_cnt_q;
    logic                      rxslip_q;
    logic                      lock_q;
    logic [SLIP_CNT_WIDTH-1:0] slip_cnt_q;

    // ------------------------------------------------------------------
    // Next-value helpers
    // ------------------------------------------------------------------
    logic                      hdr_ok;
    logic [SH_W-1:0]           sh_cnt_d;
    logic [BAD_W-1:0]          bad_cnt_d;
    logic [SLIP_CNT_WIDTH-1:0] slip_cnt_d;

    always_comb begin
        hdr_ok    = sh_is_valid(i_rx_header);
        // Neither counter can wrap: both are cleared on reaching their limit.
        sh_cnt_d  = sh_cnt_q + SH_W'(1);
        bad_cnt_d = bad_cnt_q + BAD_W'(!hdr_ok);
        // Debug slip counter sticks at all-ones rather than wrapping.
        slip_cnt_d = (&slip_cnt_q) ? slip_cnt_q : slip_cnt_q + SLIP_CNT_WIDTH'(1);
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= HUNT;
            sh_cnt_q   <= '0;
            bad_cnt_q  <= '0;
            wait_cnt_q <= '0;
            rxslip_q   <= 1'b0;
            lock_q     <= 1'b0;
            slip_cnt_q <= '0;
        end else begin
            // o_rxslip is a pulse: only the slip-issuing branches re-assert it.
            rxslip_q <= 1'b0;

            case (state_q)
                HUNT: begin
                    if (i_rx_headervalid) begin
                        if (hdr_ok) begin
                            if (sh_cnt_d == SH_LOCK_LAST) begin
                                state_q   <= LOCKED;
                                lock_q    <= 1'b1;
                                sh_cnt_q  <= '0;
                                bad_cnt_q <= '0;
                            end else begin
                                sh_cnt_q <= sh_cnt_d;
                            end
                        end else begin
                            state_q    <= SLIP_WAIT;
                            rxslip_q   <= 1'b1;
                            sh_cnt_q   <= '0;
                            bad_cnt_q  <= '0;
                            wait_cnt_q <= '0;
                            slip_cnt_q <= slip_cnt_d;
                        end
                    end
                end

                SLIP_WAIT: begin
                    // The slip pulse cycle is wait count 0, so the hold-off spans
                    // exactly SLIP_WAIT_CYCLES cycles including the pulse.
                    // Headers arriving here belong to the old alignment; drop them.
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q    <= HUNT;
                        wait_cnt_q <= '0;
                        sh_cnt_q   <= '0;
                        bad_cnt_q  <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end

                LOCKED: begin
                    if (i_rx_headervalid) begin
                        // Loss of lock is tested first so it wins when the
                        // window-closing header is also the last allowed bad one.
                        if (bad_cnt_d == BAD_LAST) begin
                            state_q    <= SLIP_WAIT;
                            lock_q     <= 1'b0;
                            rxslip_q   <= 1'b1;
                            sh_cnt_q   <= '0;
                            bad_cnt_q  <= '0;
                            wait_cnt_q <= '0;
                            slip_cnt_q <= slip_cnt_d;
                        end else if (sh_cnt_d == SH_WIN_LAST) begin
                            sh_cnt_q  <= '0;
                            bad_cnt_q <= '0;
                        end else begin
                            sh_cnt_q  <= sh_cnt_d;
                            bad_cnt_q <= bad_cnt_d;
                        end
                    end
                end

                default: begin
                    // Unused encoding: recover to a clean hunt.
                    state_q    <= HUNT;
                    lock_q     <= 1'b0;
                    sh_cnt_q   <= '0;
                    bad_cnt_q  <= '0;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    assign o_rxslip     = rxslip_q;
    assign o_block_lock = lock_q;
    assign o_state      = state_q;
    assign o_slip_count = slip_cnt_q;

endmodule

// File: tb/tb_gtx_rx_block_lock.sv
// Directed self-checking bench for gtx_rx_block_lock.
// Latency: checks sample one clock after each header is presented.
// Backpressure: n/a (bench drives headers freely).
module tb_gtx_rx_block_lock;

    logic       clk;
    logic       rst_n;
    logic [1:0] hdr;
    logic       hvld;
    logic       rxslip;
    logic       lock;
    logic [1:0] state;
    logic [7:0] slip_count;

    int checks;
    int errors;
    int slip_pulses;
    int double_slips;
    logic prev_slip;

    gtx_rx_block_lock dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_rx_header      (hdr),
        .i_rx_headervalid (hvld),
        .o_rxslip         (rxslip),
        .o_block_lock     (lock),
        .o_state          (state),
        .o_slip_count     (slip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count slip pulses and any slip held high across two cycles.
    initial begin
        slip_pulses  = 0;
        double_slips = 0;
        prev_slip    = 1'b0;
    end
    always @(negedge clk) begin
        if (rxslip) slip_pulses++;
        if (rxslip && prev_slip) double_slips++;
        prev_slip = rxslip;
    end

    // Watchdog: the run is clock-bounded, this only guards against a stuck simulator.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Present one header (or idle) for one cycle; returns just after the edge that consumed it.
    task automatic drive(input logic v, input logic [1:0] h);
        @(negedge clk);
        hvld = v;
        hdr  = h;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        hvld  = 1'b0;
        hdr   = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // 64 valid headers back to back.
    task automatic lock_up();
        for (int i = 0; i < 64; i++) drive(1'b1, (i % 2) ? 2'b10 : 2'b01);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hvld  = 1'b0;
        hdr   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rxslip !== 1'b0) begin errors++; $display("FAIL reset_rxslip: got %0b expected 0", rxslip); end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %0b expected 0", lock); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (slip_count !== 8'd0) begin errors++; $display("FAIL reset_slip_count: got %0d expected 0", slip_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lock_acquire();
        int p0;
        int early;
        early = 0;
        p0 = slip_pulses;
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, (i % 2) ? 2'b10 : 2'b01);
            if (i < 63 && lock !== 1'b0) early++;
            if (i == 63) begin
                checks++; if (lock !== 1'b1) begin errors++; $display("FAIL acquire_lock: got %0b expected 1", lock); end
                checks++; if (state !== 2'd2) begin errors++; $display("FAIL acquire_state: got %0d expected 2", state); end
            end else begin
                // Idle cycle with a garbage header that must be ignored.
                drive(1'b0, 2'b11);
            end
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL acquire_early_lock: got %0d early cycles expected 0", early); end
        checks++; if (slip_pulses - p0 !== 0) begin errors++; $display("FAIL acquire_no_slip: got %0d pulses expected 0", slip_pulses - p0); end
        checks++; if (slip_count !== 8'd0) begin errors++; $display("FAIL acquire_slip_count: got %0d expected 0", slip_count); end
    endtask

    task automatic test_slip();
        int p0;
        apply_reset();
        p0 = slip_pulses;
        drive(1'b1, 2'b00);
        checks++; if (rxslip !== 1'b1) begin errors++; $display("FAIL slip1_pulse: got %0b expected 1", rxslip); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL slip1_state: got %0d expected 1", state); end
        checks++; if (slip_count !== 8'd1) begin errors++; $display("FAIL slip1_count: got %0d expected 1", slip_count); end
        drive(1'b1, 2'b00);
        checks++; if (rxslip !== 1'b0) begin errors++; $display("FAIL slip1_width: got %0b expected 0", rxslip); end
        // 30 more invalid headers: still inside the 32-cycle hold-off.
        for (int i = 0; i < 30; i++) drive(1'b1, 2'b11);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL slip_wait_held: got %0d expected 1", state); end
        drive(1'b1, 2'b00);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL slip_wait_exit: got %0d expected 0", state); end
        checks++; if (slip_count !== 8'd1) begin errors++; $display("FAIL slip_wait_count: got %0d expected 1", slip_count); end
        checks++; if (slip_pulses - p0 !== 1) begin errors++; $display("FAIL slip_wait_pulses: got %0d expected 1", slip_pulses - p0); end
        drive(1'b1, 2'b00);
        checks++; if (rxslip !== 1'b1) begin errors++; $display("FAIL slip2_pulse: got %0b expected 1", rxslip); end
        checks++; if (slip_count !== 8'd2) begin errors++; $display("FAIL slip2_count: got %0d expected 2", slip_count); end
        drive(1'b0, 2'b00);
        checks++; if (double_slips !== 0) begin errors++; $display("FAIL slip_single_cycle: got %0d double pulses expected 0", double_slips); end
    endtask

    task automatic test_window();
        apply_reset();
        lock_up();
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL window_prelock: got %0b expected 1", lock); end
        // Window 1: 15 invalid headers (i = 0,4,...,56).
        for (int i = 0; i < 64; i++) drive(1'b1, (i % 4 == 0 && i < 60) ? 2'b00 : 2'b01);
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL window15_lock: got %0b expected 1", lock); end
        checks++; if (rxslip !== 1'b0) begin errors++; $display("FAIL window15_rxslip: got %0b expected 0", rxslip); end
        // Window 2: 16 invalid at odd positions 1..31; only reaches 16 if window 1 cleared bad_cnt.
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, (i % 2) ? 2'b11 : 2'b10);
            if (i == 30) begin
                checks++; if (lock !== 1'b1) begin errors++; $display("FAIL window16_before: got %0b expected 1", lock); end
            end
        end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL window16_lock: got %0b expected 0", lock); end
        checks++; if (rxslip !== 1'b1) begin errors++; $display("FAIL window16_rxslip: got %0b expected 1", rxslip); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL window16_state: got %0d expected 1", state); end
        checks++; if (slip_count !== 8'd1) begin errors++; $display("FAIL window16_count: got %0d expected 1", slip_count); end
    endtask

    task automatic test_priority();
        apply_reset();
        lock_up();
        // 15 invalid at 0..14, then valid up to 62, 64th header is the 16th invalid.
        for (int i = 0; i < 63; i++) drive(1'b1, (i < 15) ? 2'b00 : 2'b10);
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL priority_before: got %0b expected 1", lock); end
        drive(1'b1, 2'b11);
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL priority_lock: got %0b expected 0", lock); end
        checks++; if (rxslip !== 1'b1) begin errors++; $display("FAIL priority_rxslip: got %0b expected 1", rxslip); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1'b1, 2'b00);
        checks++; if (rxslip !== 1'b1) begin errors++; $display("FAIL rstmid_setup: got %0b expected 1", rxslip); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (rxslip !== 1'b0) begin errors++; $display("FAIL rstslip_rxslip: got %0b expected 0", rxslip); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rstslip_state: got %0d expected 0", state); end
        checks++; if (slip_count !== 8'd0) begin errors++; $display("FAIL rstslip_count: got %0d expected 0", slip_count); end
        rst_n = 1'b1;
        drive(1'b1, 2'b00);
        for (int i = 0; i < 10; i++) drive(1'b0, 2'b00);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rstwait_state: got %0d expected 0", state); end
        checks++; if (slip_count !== 8'd0) begin errors++; $display("FAIL rstwait_count: got %0d expected 0", slip_count); end
        checks++; if (rxslip !== 1'b0) begin errors++; $display("FAIL rstwait_rxslip: got %0b expected 0", rxslip); end
        rst_n = 1'b1;
        for (int i = 0; i < 63; i++) drive(1'b1, (i % 2) ? 2'b10 : 2'b01);
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL relock_63: got %0b expected 0", lock); end
        drive(1'b1, 2'b01);
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL relock_64: got %0b expected 1", lock); end
    endtask

    task automatic test_saturation();
        int p0;
        apply_reset();
        p0 = slip_pulses;
        for (int n = 1; n <= 300; n++) begin
            drive(1'b1, 2'b00);
            if (n == 254) begin
                checks++; if (slip_count !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", slip_count); end
            end
            if (n == 256) begin
                checks++; if (slip_count !== 8'd255) begin errors++; $display("FAIL sat_256: got %0d expected 255", slip_count); end
            end
            // Sparse idles covering the rest of the 32-cycle hold-off.
            for (int k = 0; k < 32; k++) drive(1'b0, 2'b00);
        end
        checks++; if (slip_count !== 8'd255) begin errors++; $display("FAIL sat_300: got %0d expected 255", slip_count); end
        checks++; if (slip_pulses - p0 !== 300) begin errors++; $display("FAIL sat_pulses: got %0d expected 300", slip_pulses - p0); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lock_acquire();
        test_slip();
        test_window();
        test_priority();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
